// File: rtl/fetch_sequencer_pkg.sv
// Shared processor definitions: fetch FSM states, opcode fields and instruction classes.
package fetch_sequencer_pkg;

    // Fetch sequencer FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXT   = 2'd2,
        ISSUE = 2'd3
    } fetch_state_t;

    // Major opcode of the two-word long-literal load (bits [15:9])
    localparam logic [6:0] LRLI_OP = 7'b1000010;

    // Instruction class field, bits [15:14]
    localparam logic [1:0] CLASS_IMM_ALU  = 2'b00;
    localparam logic [1:0] CLASS_REG_ALU  = 2'b01;
    localparam logic [1:0] CLASS_MEM_BR   = 2'b10;
    localparam logic [1:0] CLASS_LONG_LIT = 2'b11;

    // ROM default contents; fetched and issued like any other word
    localparam logic [15:0] NOP_WORD = 16'h0000;

    // True when the word is the first half of a two-word LRLI instruction
    function automatic logic is_lrli(input logic [15:0] word);
        return word[15:9] == LRLI_OP;
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: walks the program ROM, gathers the LRLI extension
// literal, and hands each complete instruction to the datapath over valid/ready.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] ir,
    output logic [INSTR_W-1:0] ext_word,
    output logic               ext_valid,
    output logic               issue_valid,
    input  logic               issue_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               busy,
    output logic [15:0]        instr_count
);

    fetch_state_t       r_state;
    fetch_state_t       w_next_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [INSTR_W-1:0] r_ext_word;
    logic               r_ext_valid;
    logic [15:0]        r_instr_count;
    logic               w_handshake;
    logic               w_rom_is_lrli;

    assign w_handshake   = (r_state == ISSUE) && issue_ready;
    assign w_rom_is_lrli = is_lrli(rom_data);

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        // NOTE: default first so every path assigns w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (run) w_next_state = FETCH;
            FETCH:   w_next_state = w_rom_is_lrli ? EXT : ISSUE;
            EXT:     w_next_state = ISSUE;
            ISSUE:   if (w_handshake) w_next_state = run ? FETCH : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Fetch datapath: pc advance, instruction/extension capture, redirect and issue count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= '0;
            r_ir          <= '0;
            r_ext_word    <= '0;
            r_ext_valid   <= 1'b0;
            r_instr_count <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    r_ir <= rom_data;
                    r_pc <= r_pc + PC_W'(1);
                    // An LRLI gets ext_valid set once its literal lands in EXT
                    if (!w_rom_is_lrli) r_ext_valid <= 1'b0;
                end
                EXT: begin
                    r_ext_word  <= rom_data;
                    r_ext_valid <= 1'b1;
                    r_pc        <= r_pc + PC_W'(1);
                end
                ISSUE: begin
                    // pc already points past the instruction unless the datapath redirects
                    if (w_handshake) begin
                        r_instr_count <= r_instr_count + 16'd1;
                        if (redirect_valid) r_pc <= redirect_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc          = r_pc;
    assign ir          = r_ir;
    assign ext_word    = r_ext_word;
    assign ext_valid   = r_ext_valid;
    assign instr_count = r_instr_count;
    assign issue_valid = (r_state == ISSUE);
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a combinational ROM model.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [7:0]  pc;
    logic [15:0] rom_data;
    logic [15:0] ir;
    logic [15:0] ext_word;
    logic        ext_valid;
    logic        issue_valid;
    logic        issue_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        busy;
    logic [15:0] instr_count;

    logic [15:0] rom [256];

    int n_tests = 0;
    int n_fail  = 0;

    fetch_sequencer #(.PC_W(8), .INSTR_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .pc             (pc),
        .rom_data       (rom_data),
        .ir             (ir),
        .ext_word       (ext_word),
        .ext_valid      (ext_valid),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .instr_count    (instr_count)
    );

    // Combinational ROM, data valid in the same cycle as the address
    assign rom_data = rom[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h00] = 16'h404A;
        rom[8'h01] = 16'h0901;
        rom[8'h16] = 16'h844A;
        rom[8'h17] = 16'h0001;

        rst_n          = 1'b0;
        run            = 1'b0;
        issue_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;

        // Reset values
        step();
        step();
        check("rst_pc",          16'(pc), 16'h0000);
        check("rst_ir",          ir, 16'h0000);
        check("rst_ext_word",    ext_word, 16'h0000);
        check("rst_ext_valid",   16'(ext_valid), 16'h0000);
        check("rst_issue_valid", 16'(issue_valid), 16'h0000);
        check("rst_busy",        16'(busy), 16'h0000);
        check("rst_count",       instr_count, 16'h0000);

        // Start: cycle 0 IDLE, cycle 1 FETCH, cycle 2 ISSUE
        rst_n       = 1'b1;
        run         = 1'b1;
        issue_ready = 1'b1;
        step();
        check("start_fetch_busy",  16'(busy), 16'h0001);
        check("start_fetch_valid", 16'(issue_valid), 16'h0000);
        check("start_fetch_pc",    16'(pc), 16'h0000);
        step();
        check("i0_valid",     16'(issue_valid), 16'h0001);
        check("i0_ir",        ir, 16'h404A);
        check("i0_ext_valid", 16'(ext_valid), 16'h0000);
        check("i0_pc",        16'(pc), 16'h0001);
        step();
        check("i0_hs_count", instr_count, 16'h0001);
        check("i1_fetch_pc", 16'(pc), 16'h0001);
        step();
        check("i1_valid", 16'(issue_valid), 16'h0001);
        check("i1_ir",    ir, 16'h0901);
        check("i1_pc",    16'(pc), 16'h0002);

        // Redirect to the two-word instruction at 8'h16
        redirect_valid = 1'b1;
        redirect_pc    = 8'h16;
        step();
        redirect_valid = 1'b0;
        check("i1_hs_count", instr_count, 16'h0002);
        check("redir16_pc",  16'(pc), 16'h0016);
        step();
        check("ext_state_valid", 16'(issue_valid), 16'h0000);
        check("ext_state_busy",  16'(busy), 16'h0001);
        check("ext_state_ir",    ir, 16'h844A);
        step();
        check("lrli_valid",     16'(issue_valid), 16'h0001);
        check("lrli_ir",        ir, 16'h844A);
        check("lrli_ext_valid", 16'(ext_valid), 16'h0001);
        check("lrli_ext_word",  ext_word, 16'h0001);
        check("lrli_next_pc",   16'(pc), 16'h0018);

        // Backpressure, with a redirect that must be ignored while ready=0
        issue_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h55;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 16'(issue_valid), 16'h0001);
            check("bp_ir",    ir, 16'h844A);
            check("bp_pc",    16'(pc), 16'h0018);
            check("bp_count", instr_count, 16'h0002);
        end

        // Handshake with redirect to 8'h20
        issue_ready    = 1'b1;
        redirect_pc    = 8'h20;
        step();
        issue_ready    = 1'b0;
        redirect_valid = 1'b0;
        check("redir20_count", instr_count, 16'h0003);
        check("redir20_pc",    16'(pc), 16'h0020);
        check("redir20_valid", 16'(issue_valid), 16'h0000);
        step();
        check("nop_ir",        ir, 16'h0000);
        check("nop_ext_valid", 16'(ext_valid), 16'h0000);
        check("nop_valid",     16'(issue_valid), 16'h0001);
        check("one_hs_count",  instr_count, 16'h0003);

        // Wrap: LRLI at 8'hFF takes its literal from 8'h00
        rom[8'hFF]     = 16'h8401;
        rom[8'h00]     = 16'h0001;
        issue_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFF;
        step();
        issue_ready    = 1'b0;
        redirect_valid = 1'b0;
        check("wrap_redir_pc", 16'(pc), 16'h00FF);
        check("wrap_count",    instr_count, 16'h0004);
        step();
        check("wrap_fetch_pc", 16'(pc), 16'h0000);
        step();
        check("wrap_ir",        ir, 16'h8401);
        check("wrap_ext_word",  ext_word, 16'h0001);
        check("wrap_ext_valid", 16'(ext_valid), 16'h0001);
        check("wrap_pc",        16'(pc), 16'h0001);

        // run=0 at the handshake parks in IDLE with pc held
        run         = 1'b0;
        issue_ready = 1'b1;
        step();
        check("park_busy",  16'(busy), 16'h0000);
        check("park_valid", 16'(issue_valid), 16'h0000);
        check("park_pc",    16'(pc), 16'h0001);
        check("park_count", instr_count, 16'h0005);
        step();
        check("park_hold_busy", 16'(busy), 16'h0000);
        check("park_hold_pc",   16'(pc), 16'h0001);

        // Reset asserted while in EXT
        rom[8'h01] = 16'h844A;
        run        = 1'b1;
        step();
        check("rx_fetch_pc", 16'(pc), 16'h0001);
        step();
        check("rx_ext_busy",  16'(busy), 16'h0001);
        check("rx_ext_valid", 16'(issue_valid), 16'h0000);
        check("rx_ext_pc",    16'(pc), 16'h0002);
        rst_n = 1'b0;
        #1;
        check("rx_pc",          16'(pc), 16'h0000);
        check("rx_ir",          ir, 16'h0000);
        check("rx_ext_word",    ext_word, 16'h0000);
        check("rx_ext_valid_o", 16'(ext_valid), 16'h0000);
        check("rx_issue_valid", 16'(issue_valid), 16'h0000);
        check("rx_busy",        16'(busy), 16'h0000);
        check("rx_count",       instr_count, 16'h0000);
        step();
        check("rx_held_busy", 16'(busy), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the 16-bit program ROM for the processor datapath. Drives the 8-bit ROM address, registers the returned instruction word, detects the two-word LRLI form and fetches its extension literal. Presents each complete instruction to the datapath with a valid/ready handshake and applies PC redirects (branch, jump, call, return) resolved by the datapath. Sits between the ROM and the decode/execute stage.

## Interface
- PC_W, 8, ROM address width
- INSTR_W, 16, instruction word width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 allows fetching, 0 parks the block in IDLE after the current issue
- pc  out  PC_W  ROM address; ROM is combinational, data is valid in the same cycle
- rom_data  in  INSTR_W  ROM read data
- ir  out  INSTR_W  registered instruction word
- ext_word  out  INSTR_W  registered extension literal; meaningful only when ext_valid=1
- ext_valid  out  1  current issued instruction is two-word
- issue_valid  out  1  ir/ext_word are held stable for the datapath
- issue_ready  in  1  datapath accepts the instruction
- redirect_valid  in  1  sampled only on an issue handshake
- redirect_pc  in  PC_W  next fetch address when redirect_valid=1
- busy  out  1  state != IDLE
- instr_count  out  16  number of completed issue handshakes

## Operation
- States: IDLE, FETCH, EXT, ISSUE.
- IDLE: if run=1, go to FETCH next cycle; otherwise stay in IDLE.
- FETCH: ir <= rom_data; pc <= pc+1. If rom_data[15:9] == LRLI_OP (7'b1000010), go to EXT; otherwise clear ext_valid and go to ISSUE.
- EXT: ext_word <= rom_data; ext_valid <= 1; pc <= pc+1; go to ISSUE.
- ISSUE: issue_valid=1, decoded from state. ir, ext_word and ext_valid stay frozen until the handshake. A handshake is issue_valid & issue_ready. On a handshake:
  - instr_count increments, wrapping 16'hFFFF→0.
  - If redirect_valid=1, pc <= redirect_pc; else pc is unchanged (it already points past the instruction).
  - Next state is FETCH if run=1, else IDLE.
- pc arithmetic is modulo 2^PC_W: 8'hFF+1 = 8'h00. An LRLI at 8'hFF takes its extension word from 8'h00.
- The all-zero word (ROM default/NOP) is fetched and issued like any other word. The sequencer never interprets opcodes except LRLI_OP.
- redirect_valid outside a handshake is ignored.
- Reset mid-operation returns to IDLE with all reset values, whatever the state. A pending issue is discarded.
- Reset values: pc=0, ir=0, ext_word=0, ext_valid=0, issue_valid=0, busy=0, instr_count=0, state=IDLE.

## Timing
- After rst_n deasserts with run=1: cycle 0 IDLE, cycle 1 FETCH (pc=0), cycle 2 ISSUE.
- Single-word instruction, issue_ready held high: 2 cycles per instruction (FETCH, ISSUE).
- Two-word instruction: 3 cycles (FETCH, EXT, ISSUE).
- Each cycle with issue_ready=0 adds one ISSUE cycle.
- The redirect target is on pc in the cycle immediately after the handshake (FETCH). There is no redirect bubble beyond that.
- All outputs are registered except issue_valid and busy, which are decoded from the state register only and have no input-to-output combinational path.

## Structure
- The shared processor package holds:
  - state enum {IDLE, FETCH, EXT, ISSUE}
  - LRLI_OP = 7'b1000010
  - class constants for bits[15:14] (00 imm-ALU, 01 reg-ALU, 10 mem/branch, 11 long-literal)
  - NOP_WORD = 16'h0000
- One module, no sub-modules. The ROM is instantiated by the parent.

## Test plan
- Reset/start: ROM[0]=16'h404A, ROM[1]=16'h0901, run=1, ready=1.
  - Issues 16'h404A then 16'h0901 on cycles 2 and 4.
  - pc reads 2 afterwards; instr_count=2.
- Two-word: ROM[8'h16]=16'h844A, ROM[8'h17]=16'h0001, redirect to 8'h16.
  - Issues ir=16'h844A, ext_valid=1, ext_word=16'h0001.
  - Next fetch from 8'h18.
- Backpressure: hold issue_ready=0 for 5 cycles in ISSUE.
  - ir, pc and instr_count stay constant.
  - Exactly one handshake when ready rises.
- Redirect: handshake with redirect_valid=1, redirect_pc=8'h20.
  - Next FETCH has pc=8'h20.
  - Asserting redirect_valid with ready=0 has no effect.
- Wrap: LRLI at 8'hFF with ROM[0]=16'h0001.
  - ext_word=16'h0001 and pc=8'h01 after the issue.
- Reset mid-EXT, and run=0 at a handshake:
  - Reset mid-EXT: all outputs return to reset values.
  - run=0 at a handshake: state IDLE, busy=0, pc held.
